// File: rtl/auth_sequencer_pkg.sv
// Shared encodings for the authentication sequencer: one-hot states, phase indices
// and the enable decoder used by the top level.
package auth_sequencer_pkg;

   localparam int SIZE_OF_STATES_SEQ = 5;

   typedef enum logic [SIZE_OF_STATES_SEQ-1:0] {
      ST_IDLE    = 5'b00001,
      ST_RUN     = 5'b00010,
      ST_RELEASE = 5'b00100,
      ST_DONE    = 5'b01000,
      ST_FAIL    = 5'b10000
   } seq_state_t;

   localparam logic [1:0] PHASE_DIGESTS = 2'd0;
   localparam logic [1:0] PHASE_CERT    = 2'd1;
   localparam logic [1:0] PHASE_CHAL    = 2'd2;
   localparam logic [1:0] FAIL_ABORT    = 2'd3;

   // Index 3 shifts out of the 3-bit field and yields no enable.
   function automatic logic [2:0] phase_onehot(input logic [1:0] phase);
      return 3'b001 << phase;
   endfunction

endpackage

// File: rtl/auth_phase_timer.sv
// Per-phase watchdog: 16-bit up-counter with clear (dominant) and enable, flagging
// expiry when the count reaches TIMEOUT_CYCLES-1.
module auth_phase_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/auth_sequencer.sv
// Sequences the digests, certificate and challenge phase controllers for one slot.
// Optional retry support is enabled with the AUTH_RETRY_EN macro.
module auth_sequencer
   import auth_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_RETRIES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] slot,
   input  logic [2:0] phase_done,
   input  logic [2:0] phase_failed,
   output logic [2:0] phase_en,
   output logic [1:0] slot_out,
   output logic       busy,
   output logic       auth_done,
   output logic       auth_failed,
   output logic [1:0] fail_phase,
   output logic       fail_timeout,
   output logic [1:0] retry_count
);

   seq_state_t state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [1:0] retry_q, retry_d;
   logic [1:0] slot_d;
   logic [1:0] fail_phase_d;
   logic       fail_timeout_d;
   logic       expired;
   logic       hit_done, hit_failed, hit_any_fail, retry_ok;

   auth_phase_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .clear  (state_q != ST_RUN),
      .enable (state_q == ST_RUN),
      .expired(expired)
   );

   // Only the bit of the active phase is observed.
   assign hit_done     = |(phase_done   & phase_onehot(phase_q));
   assign hit_failed   = |(phase_failed & phase_onehot(phase_q));
   assign hit_any_fail = hit_failed | expired;

`ifdef AUTH_RETRY_EN
   assign retry_ok = (retry_q < 2'(MAX_RETRIES));
`else
   assign retry_ok = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      retry_d        = retry_q;
      slot_d         = slot_out;
      fail_phase_d   = fail_phase;
      fail_timeout_d = fail_timeout;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d        = ST_RUN;
               phase_d        = PHASE_DIGESTS;
               retry_d        = 2'd0;
               slot_d         = slot;
               fail_phase_d   = 2'd0;
               fail_timeout_d = 1'b0;
            end
         end
         ST_RUN: begin
            // Priority: abort, then failure/timeout, then done.
            if (abort) begin
               state_d        = ST_FAIL;
               fail_phase_d   = FAIL_ABORT;
               fail_timeout_d = 1'b0;
            end else if (hit_any_fail) begin
               if (retry_ok) begin
                  state_d = ST_RELEASE;
                  retry_d = retry_q + 2'd1;
               end else begin
                  state_d        = ST_FAIL;
                  fail_phase_d   = phase_q;
                  fail_timeout_d = ~hit_failed;
               end
            end else if (hit_done) begin
               if (phase_q == PHASE_CHAL) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RELEASE;
                  phase_d = phase_q + 2'd1;
                  retry_d = 2'd0;
               end
            end
         end
         ST_RELEASE: begin
            if (abort) begin
               state_d        = ST_FAIL;
               fail_phase_d   = FAIL_ABORT;
               fail_timeout_d = 1'b0;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE, ST_FAIL: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d        = ST_RUN;
               phase_d        = PHASE_DIGESTS;
               retry_d        = 2'd0;
               slot_d         = slot;
               fail_phase_d   = 2'd0;
               fail_timeout_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they track the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         phase_q      <= PHASE_DIGESTS;
         retry_q      <= 2'd0;
         phase_en     <= 3'b000;
         slot_out     <= 2'd0;
         busy         <= 1'b0;
         auth_done    <= 1'b0;
         auth_failed  <= 1'b0;
         fail_phase   <= 2'd0;
         fail_timeout <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         retry_q      <= retry_d;
         phase_en     <= (state_d == ST_RUN) ? phase_onehot(phase_d) : 3'b000;
         slot_out     <= slot_d;
         busy         <= (state_d == ST_RUN) || (state_d == ST_RELEASE);
         auth_done    <= (state_d == ST_DONE);
         auth_failed  <= (state_d == ST_FAIL);
         fail_phase   <= fail_phase_d;
         fail_timeout <= fail_timeout_d;
      end
   end

   assign retry_count = retry_q;

endmodule

// File: tb/tb_auth_sequencer.sv
// Directed self-checking bench for auth_sequencer (TIMEOUT_CYCLES=16, MAX_RETRIES=1).
module tb_auth_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic [1:0] slot;
   logic [2:0] phase_done, phase_failed;
   logic [2:0] phase_en;
   logic [1:0] slot_out, fail_phase, retry_count;
   logic       busy, auth_done, auth_failed, fail_timeout;
   int         checks = 0;
   int         errors = 0;

   auth_sequencer #(
      .TIMEOUT_CYCLES(16),
      .MAX_RETRIES   (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .slot        (slot),
      .phase_done  (phase_done),
      .phase_failed(phase_failed),
      .phase_en    (phase_en),
      .slot_out    (slot_out),
      .busy        (busy),
      .auth_done   (auth_done),
      .auth_failed (auth_failed),
      .fail_phase  (fail_phase),
      .fail_timeout(fail_timeout),
      .retry_count (retry_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic advance_to_chal(input logic [1:0] s);
      slot = s; start = 1'b1; tick(); start = 1'b0;
      phase_done = 3'b001; tick(); phase_done = 3'b000;
      tick();
      phase_done = 3'b010; tick(); phase_done = 3'b000;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; slot = 2'd0;
      phase_done = 3'b000; phase_failed = 3'b000;
      tick(); tick();
      checks++; if ({phase_en, slot_out, busy, auth_done, auth_failed, fail_phase, fail_timeout, retry_count} !== 13'd0) begin
         errors++; $display("FAIL reset_outputs got %b exp 0", {phase_en, slot_out, busy, auth_done, auth_failed, fail_phase, fail_timeout, retry_count}); end
      reset = 1'b1; tick();
      checks++; if (busy !== 1'b0 || phase_en !== 3'b000) begin
         errors++; $display("FAIL idle_after_reset got busy=%b en=%b exp 0/000", busy, phase_en); end
   endtask

   task automatic test_nominal();
      slot = 2'd2; start = 1'b1; tick(); start = 1'b0; slot = 2'd0;
      checks++; if (busy !== 1'b1 || slot_out !== 2'd2) begin
         errors++; $display("FAIL nom_busy_slot got busy=%b slot=%0d exp 1/2", busy, slot_out); end
      for (int p = 0; p < 3; p++) begin
         checks++; if (phase_en !== (3'b001 << p)) begin
            errors++; $display("FAIL nom_en_p%0d got %b exp %b", p, phase_en, 3'b001 << p); end
         tick(); tick();
         phase_done = 3'b001 << p; tick(); phase_done = 3'b000;
         if (p < 2) begin
            checks++; if (phase_en !== 3'b000 || busy !== 1'b1) begin
               errors++; $display("FAIL nom_release_p%0d got en=%b busy=%b exp 000/1", p, phase_en, busy); end
            tick();
         end
      end
      checks++; if (auth_done !== 1'b1 || auth_failed !== 1'b0 || busy !== 1'b0 || phase_en !== 3'b000) begin
         errors++; $display("FAIL nom_done got done=%b failed=%b busy=%b en=%b exp 1/0/0/000", auth_done, auth_failed, busy, phase_en); end
      checks++; if (fail_phase !== 2'd0 || slot_out !== 2'd2) begin
         errors++; $display("FAIL nom_status got fail_phase=%0d slot=%0d exp 0/2", fail_phase, slot_out); end
      tick();
      checks++; if (auth_done !== 1'b1) begin
         errors++; $display("FAIL nom_done_held got %b exp 1", auth_done); end
   endtask

   task automatic test_restart_from_done();
      slot = 2'd1; start = 1'b1; tick(); start = 1'b0;
      checks++; if (auth_done !== 1'b0 || phase_en !== 3'b001 || slot_out !== 2'd1) begin
         errors++; $display("FAIL restart got done=%b en=%b slot=%0d exp 0/001/1", auth_done, phase_en, slot_out); end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if (auth_failed !== 1'b1 || fail_phase !== 2'd3 || fail_timeout !== 1'b0 || phase_en !== 3'b000) begin
         errors++; $display("FAIL abort_run got failed=%b fp=%0d to=%b en=%b exp 1/3/0/000", auth_failed, fail_phase, fail_timeout, phase_en); end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if (auth_failed !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_to_idle got failed=%b busy=%b exp 0/0", auth_failed, busy); end
   endtask

   task automatic test_abort_with_done();
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if (busy !== 1'b0 || auth_failed !== 1'b0) begin
         errors++; $display("FAIL abort_idle got busy=%b failed=%b exp 0/0", busy, auth_failed); end
      start = 1'b1; tick(); start = 1'b0;
      phase_done = 3'b001; abort = 1'b1; tick(); phase_done = 3'b000; abort = 1'b0;
      checks++; if (auth_failed !== 1'b1 || fail_phase !== 2'd3 || phase_en !== 3'b000) begin
         errors++; $display("FAIL abort_vs_done got failed=%b fp=%0d en=%b exp 1/3/000", auth_failed, fail_phase, phase_en); end
   endtask

   task automatic test_timeout();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         if (k == 1) begin phase_done = 3'b100; phase_failed = 3'b010; end
         tick();
         phase_done = 3'b000; phase_failed = 3'b000;
         checks++; if (phase_en !== 3'b001 || auth_failed !== 1'b0) begin
            errors++; $display("FAIL timeout_wait_c%0d got en=%b failed=%b exp 001/0", k, phase_en, auth_failed); end
      end
      tick();
      checks++; if (auth_failed !== 1'b1 || fail_timeout !== 1'b1 || fail_phase !== 2'd0 || phase_en !== 3'b000) begin
         errors++; $display("FAIL timeout_fire got failed=%b to=%b fp=%0d en=%b exp 1/1/0/000", auth_failed, fail_timeout, fail_phase, phase_en); end
   endtask

   task automatic test_cert_failure();
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (auth_failed !== 1'b0 || fail_timeout !== 1'b0) begin
         errors++; $display("FAIL cert_status_clear got failed=%b to=%b exp 0/0", auth_failed, fail_timeout); end
      phase_done = 3'b001; tick(); phase_done = 3'b000;
      tick();
      phase_failed = 3'b010; tick(); phase_failed = 3'b000;
`ifdef AUTH_RETRY_EN
      checks++; if (retry_count !== 2'd1 || busy !== 1'b1 || phase_en !== 3'b000) begin
         errors++; $display("FAIL cert_retry got rc=%0d busy=%b en=%b exp 1/1/000", retry_count, busy, phase_en); end
      tick();
      checks++; if (phase_en !== 3'b010) begin
         errors++; $display("FAIL cert_retry_en got %b exp 010", phase_en); end
      phase_failed = 3'b010; tick(); phase_failed = 3'b000;
`endif
      checks++; if (auth_failed !== 1'b1 || fail_phase !== 2'd1 || fail_timeout !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL cert_fail got failed=%b fp=%0d to=%b busy=%b exp 1/1/0/0", auth_failed, fail_phase, fail_timeout, busy); end
   endtask

   task automatic test_simultaneous_chal();
      advance_to_chal(2'd3);
      checks++; if (phase_en !== 3'b100) begin
         errors++; $display("FAIL chal_en got %b exp 100", phase_en); end
      phase_done = 3'b100; phase_failed = 3'b100; tick();
      phase_done = 3'b000; phase_failed = 3'b000;
`ifdef AUTH_RETRY_EN
      checks++; if (retry_count !== 2'd1 || busy !== 1'b1 || auth_done !== 1'b0) begin
         errors++; $display("FAIL chal_both got rc=%0d busy=%b done=%b exp 1/1/0", retry_count, busy, auth_done); end
`else
      checks++; if (auth_failed !== 1'b1 || fail_phase !== 2'd2 || auth_done !== 1'b0 || retry_count !== 2'd0) begin
         errors++; $display("FAIL chal_both got failed=%b fp=%0d done=%b rc=%0d exp 1/2/0/0", auth_failed, fail_phase, auth_done, retry_count); end
`endif
   endtask

   task automatic test_reset_mid_run();
      abort = 1'b1; tick(); abort = 1'b0;
      advance_to_chal(2'd1);
      checks++; if (phase_en !== 3'b100 || slot_out !== 2'd1) begin
         errors++; $display("FAIL rst_pre got en=%b slot=%0d exp 100/1", phase_en, slot_out); end
      reset = 1'b0; tick();
      checks++; if ({phase_en, slot_out, busy, auth_done, auth_failed, fail_phase, fail_timeout, retry_count} !== 13'd0) begin
         errors++; $display("FAIL rst_mid got %b exp 0", {phase_en, slot_out, busy, auth_done, auth_failed, fail_phase, fail_timeout, retry_count}); end
      reset = 1'b1; tick();
      checks++; if (busy !== 1'b0) begin
         errors++; $display("FAIL rst_idle got busy=%b exp 0", busy); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_restart_from_done();
      test_abort_with_done();
      test_timeout();
      test_cert_failure();
      test_simultaneous_chal();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
